key_cmd_queue: RTL and testbench

Consumer end of the debounced key-pulse interface. Accepts the one-cycle press pulses produced per button by the debouncers and turns them into an ordered stream of game commands. Commands are offered to the game-control FSM over a valid/ready handshake. Sits between the four button debouncers and the piece-movement logic; no press is lost silently.

---
 rtl/key_cmd_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 52 +++++
 rtl/key_cmd_queue.sv | 81 ++++++++
 tb/tb_key_cmd_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// Shared types and helpers for the key press to game command queue.
package key_cmd_pkg;

  localparam int unsigned NUM_KEYS = 4;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'b00,
    CMD_RIGHT = 2'b01,
    CMD_ROT   = 2'b10,
    CMD_DROP  = 2'b11
  } cmd_t;

  // Highest-priority pending key: drop > rotate > left > right.
  function automatic cmd_t prio_enc(input logic [NUM_KEYS-1:0] pend);
    if (pend[3])      return CMD_DROP;
    else if (pend[2]) return CMD_ROT;
    else if (pend[0]) return CMD_LEFT;
    else              return CMD_RIGHT;
  endfunction

  function automatic logic [NUM_KEYS-1:0] cmd_onehot(input cmd_t c);
    return NUM_KEYS'(1) << c;
  endfunction

  function automatic logic [2:0] popcount4(input logic [NUM_KEYS-1:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with a registered occupancy count; push while full is
// accepted only when a pop frees a slot in the same cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  // Memory is cleared on reset so the head reads 00 while empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/key_cmd_queue.sv
// Latches debounced key pulses into a pending set and drains them, one per
// cycle in priority order, into a command FIFO; lost presses are counted.
module key_cmd_queue
  import key_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_rot,
  input  logic             key_drop,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  input  logic             cmd_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned SW = CNT_W + 3;

  logic [NUM_KEYS-1:0]      pulses;
  logic [NUM_KEYS-1:0]      pend;
  logic [NUM_KEYS-1:0]      xfer_mask;
  logic [NUM_KEYS-1:0]      drops;
  cmd_t                     xfer_cmd;
  logic                     xfer;
  logic                     can_accept;
  logic                     fifo_pop;
  logic [1:0]               fifo_dout;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [SW-1:0]            drop_sum;
  logic [CNT_W-1:0]         drop_next;

  // Transfer selection and drop accounting.
  always_comb begin
    pulses     = {key_drop, key_rot, key_right, key_left};
    xfer_cmd   = prio_enc(pend);
    fifo_pop   = cmd_ready && !fifo_empty;
    can_accept = !fifo_full || fifo_pop;
    xfer       = (pend != '0) && can_accept;
    xfer_mask  = xfer ? cmd_onehot(xfer_cmd) : '0;
    drops      = pulses & pend & ~xfer_mask;
    drop_sum   = SW'(drop_cnt) + SW'(popcount4(drops));
    drop_next  = (drop_sum[SW-1:CNT_W] != '0) ? '1 : drop_sum[CNT_W-1:0];
    cmd_valid  = (fifo_count != '0);
    cmd_code   = fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pend     <= (pend & ~xfer_mask) | pulses;
      drop_cnt <= drop_next;
      if (drops != '0) overflow <= 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (fifo_pop),
    .din   (xfer_cmd),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_key_cmd_queue.sv
// Bench for key_cmd_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_cmd_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_left = 1'b0, key_right = 1'b0, key_rot = 1'b0, key_drop = 1'b0;
  logic             cmd_ready = 1'b0;
  logic             cmd_valid;
  logic [1:0]       cmd_code;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  key_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_left  (key_left),
    .key_right (key_right),
    .key_rot   (key_rot),
    .key_drop  (key_drop),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Reference model: a pending set of keys and a queue of command codes.
  logic [1:0] m_q[$];
  logic [3:0] m_pend = '0;
  int         m_drop = 0;
  bit         m_ovf  = 0;
  int         prio[4] = '{3, 2, 0, 1};
  logic [3:0] m_pulses;
  bit         m_pop, m_room;
  int         m_xk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_q.delete();
      m_pend = '0;
      m_drop = 0;
      m_ovf  = 0;
    end else begin
      m_pulses = {key_drop, key_rot, key_right, key_left};
      m_pop    = (m_q.size() != 0) && cmd_ready;
      m_room   = (m_q.size() < DEPTH) || m_pop;
      m_xk     = -1;
      if (m_room)
        for (int i = 0; i < 4; i++)
          if (m_xk < 0 && m_pend[prio[i]]) m_xk = prio[i];
      for (int k = 0; k < 4; k++)
        if (m_pulses[k] && m_pend[k] && k != m_xk) begin
          m_drop++;
          m_ovf = 1;
        end
      if (m_drop > CNT_MAX) m_drop = CNT_MAX;
      if (m_pop) void'(m_q.pop_front());
      if (m_xk >= 0) begin
        m_q.push_back(2'(m_xk));
        m_pend[m_xk] = 1'b0;
      end
      m_pend = m_pend | m_pulses;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("model_valid", 32'(cmd_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("model_code", 32'(cmd_code), 32'(m_q[0]));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
      check("model_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_drop, key_rot, key_right, key_left} = k;
  endtask

  logic [1:0] exp3[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic [1:0] exp4[5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
  logic [3:0] seq3[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] seq4[4] = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};

  initial begin
    // Reset state
    step(); step();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_code", 32'(cmd_code), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Single rotate: visible for exactly one cycle, two cycles after the pulse
    cmd_ready = 1'b1;
    set_keys(4'b0100); step(); set_keys(4'b0000);
    check("rot_n1_valid", 32'(cmd_valid), 32'd0);
    step();
    check("rot_n2_valid", 32'(cmd_valid), 32'd1);
    check("rot_n2_code", 32'(cmd_code), 32'd2);
    step();
    check("rot_n3_valid", 32'(cmd_valid), 32'd0);
    check("rot_drop_cnt", 32'(drop_cnt), 32'd0);

    // Simultaneous left/right/drop drain in priority order
    set_keys(4'b1011); step(); set_keys(4'b0000);
    check("multi_n1_valid", 32'(cmd_valid), 32'd0);
    step(); check("multi_code0", 32'(cmd_code), 32'd3);
    step(); check("multi_code1", 32'(cmd_code), 32'd0);
    step(); check("multi_code2", 32'(cmd_code), 32'd1);
    step(); check("multi_done", 32'(cmd_valid), 32'd0);

    // Fill FIFO with ready low, repeat pending keys, then drain
    cmd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_keys(seq3[i]); step();
    end
    set_keys(4'b0011); step(); set_keys(4'b0000);
    check("fill_drop_cnt", 32'(drop_cnt), 32'd2);
    check("fill_overflow", 32'(overflow), 32'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("fill_drain_valid", 32'(cmd_valid), 32'd1);
      check("fill_drain_code", 32'(cmd_code), 32'(exp3[i]));
      step();
    end
    check("fill_drain_done", 32'(cmd_valid), 32'd0);

    // Full FIFO, two left pulses: second is dropped, one left queued
    rst = 1'b1; step(); rst = 1'b0;
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_keys(seq4[i]); step();
    end
    set_keys(4'b0000); step();
    set_keys(4'b0001); step();
    set_keys(4'b0001); step();
    set_keys(4'b0000);
    check("full_left_drop_cnt", 32'(drop_cnt), 32'd1);
    check("full_left_overflow", 32'(overflow), 32'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("full_drain_code", 32'(cmd_code), 32'(exp4[i]));
      step();
    end
    check("full_drain_done", 32'(cmd_valid), 32'd0);

    // Mid-operation reset with queued commands and pending keys
    cmd_ready = 1'b0;
    set_keys(4'b1110); step(); set_keys(4'b0000);
    step(); step();
    set_keys(4'b0101); step(); set_keys(4'b0000);
    check("prerst_valid", 32'(cmd_valid), 32'd1);
    check("prerst_code", 32'(cmd_code), 32'd3);
    rst = 1'b1; set_keys(4'b0001); step();
    rst = 1'b0; set_keys(4'b0000);
    check("midrst_valid", 32'(cmd_valid), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    cmd_ready = 1'b1;
    set_keys(4'b1000); step(); set_keys(4'b0000);
    check("postrst_n1_valid", 32'(cmd_valid), 32'd0);
    step();
    check("postrst_n2_valid", 32'(cmd_valid), 32'd1);
    check("postrst_n2_code", 32'(cmd_code), 32'd3);
    step();
    check("postrst_done", 32'(cmd_valid), 32'd0);

    // Drop counter saturation
    cmd_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      set_keys(4'b1111); step();
    end
    set_keys(4'b0000); step();
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    check("sat_overflow", 32'(overflow), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
